// File: rtl/beltwarn_ctrl_pkg.sv
// Shared definitions for the seat-belt warning controller: state encodings,
// default timing constants and counter width.
package beltwarn_ctrl_pkg;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_CHIME = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;
  localparam logic [1:0] ST_ESC   = 2'd3;

  localparam int DEF_TICK_DIV    = 4;
  localparam int DEF_CHIME_TICKS = 6;
  localparam int DEF_FLASH_TICKS = 2;
  localparam int DEF_ESC_TICKS   = 10;

  localparam int TCNT_W = 16;

  // States in which the lamp follows the flashing phase bit.
  function automatic logic is_flashing(input logic [1:0] st);
    return (st == ST_FLASH) || (st == ST_ESC);
  endfunction

endpackage

// File: rtl/beltwarn_ctrl_if.sv
// Sensor inputs and lamp/chime driver outputs of the warning controller.
interface beltwarn_ctrl_if;
  logic       K;
  logic       P;
  logic       S;
  logic       lamp;
  logic       chime;
  logic       esc;
  logic [1:0] state;

  modport master (output K, P, S, input lamp, chime, esc, state);
  modport slave  (input K, P, S, output lamp, chime, esc, state);
endinterface

// File: rtl/beltwarn_ctrl_tick.sv
// Timing prescaler: pulses tick once every TICK_DIV cycles, restartable by clr.
module beltwarn_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beltwarn_ctrl.sv
// Seat-belt warning sequencer: OFF -> CHIME -> FLASH -> ESC, driven by the
// registered raw condition K & P & ~S. Outputs are decoded from registered state.
module beltwarn_ctrl
  import beltwarn_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int CHIME_TICKS = DEF_CHIME_TICKS,
  parameter int FLASH_TICKS = DEF_FLASH_TICKS,
  parameter int ESC_TICKS   = DEF_ESC_TICKS
) (
  input  logic            clk,
  input  logic            rst,
  beltwarn_ctrl_if.slave  bus
);

  localparam logic [TCNT_W-1:0] CHIME_LAST = TCNT_W'(CHIME_TICKS - 1);
  localparam logic [TCNT_W-1:0] ESC_LAST   = TCNT_W'(ESC_TICKS - 1);
  localparam logic [TCNT_W-1:0] FLASH_LAST = TCNT_W'(FLASH_TICKS - 1);

  logic              r_w_q;
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] r_fcnt;
  logic              r_phase;
  logic              w_tick;
  logic              w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_q <= 1'b0;
    end else begin
      r_w_q <= bus.K & bus.P & ~bus.S;
    end
  end

  // Losing the warning condition always wins over a timed transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF:   if (r_w_q) w_state_next = ST_CHIME;
      ST_CHIME: begin
        if (!r_w_q)                             w_state_next = ST_OFF;
        else if (w_tick && r_tcnt == CHIME_LAST) w_state_next = ST_FLASH;
      end
      ST_FLASH: begin
        if (!r_w_q)                           w_state_next = ST_OFF;
        else if (w_tick && r_tcnt == ESC_LAST) w_state_next = ST_ESC;
      end
      ST_ESC:   if (!r_w_q) w_state_next = ST_OFF;
      default:  w_state_next = ST_OFF;
    endcase
  end

  assign w_clr = (w_state_next != r_state);

  beltwarn_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Every state entry restarts the timing so each phase has an exact length.
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_clr) begin
      r_fcnt  <= '0;
      r_phase <= is_flashing(w_state_next);
    end else if (w_tick) begin
      if (r_fcnt == FLASH_LAST) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt  <= r_fcnt + 1'b1;
      end
    end
  end

  assign bus.state = r_state;
  assign bus.esc   = (r_state == ST_ESC);
  assign bus.lamp  = (r_state == ST_CHIME) | (is_flashing(r_state) & r_phase);
  assign bus.chime = (r_state == ST_CHIME) | ((r_state == ST_ESC) & r_phase);

endmodule

// File: tb/tb_beltwarn_ctrl.sv
// Self-checking bench for beltwarn_ctrl: directed scenarios plus random inputs
// against a cycle-age reference model of the warning sequence.
module tb_beltwarn_ctrl;

  localparam int TD = 4;
  localparam int CT = 6;
  localparam int FT = 2;
  localparam int ET = 10;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  // Reference model: state number, registered warning, cycles since state entry.
  int   m_st;
  logic m_wq;
  int   m_age;

  beltwarn_ctrl_if bw_if ();

  beltwarn_ctrl #(
    .TICK_DIV    (TD),
    .CHIME_TICKS (CT),
    .FLASH_TICKS (FT),
    .ESC_TICKS   (ET)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic k, input logic p, input logic s);
    if (r) begin
      m_st = 0; m_wq = 1'b0; m_age = 0;
    end else begin
      if (m_st == 0) begin
        if (m_wq) begin m_st = 1; m_age = 0; end
      end else if (!m_wq) begin
        m_st = 0; m_age = 0;
      end else begin
        m_age++;
        if (m_st == 1 && m_age == CT * TD) begin m_st = 2; m_age = 0; end
        else if (m_st == 2 && m_age == ET * TD) begin m_st = 3; m_age = 0; end
      end
      m_wq = k & p & ~s;
    end
  endtask

  function automatic logic [4:0] exp_vec();
    logic lamp, chime, esc;
    lamp  = (m_st == 1) || ((m_st >= 2) && (((m_age / (FT * TD)) % 2) == 0));
    chime = (m_st == 1) || ((m_st == 3) && lamp);
    esc   = (m_st == 3);
    return {lamp, chime, esc, 2'(m_st)};
  endfunction

  function automatic logic [4:0] got_vec();
    return {bw_if.lamp, bw_if.chime, bw_if.esc, bw_if.state};
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic r, input logic k, input logic p, input logic s);
    rst = r; bw_if.K = k; bw_if.P = p; bw_if.S = s;
    @(posedge clk);
    model_step(r, k, p, s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (got_vec() !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b expected 00000", i, got_vec());
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (bw_if.state !== 2'd0 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_rel1: got %b expected %b", got_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (bw_if.state !== 2'd1 || got_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_rel2: got %b expected state 01 (%b)", got_vec(), exp_vec());
    end
    $display("test_reset done: %0d compared", n_cmp);
  endtask

  task automatic test_full_sequence();
    int chime_cyc = 1;
    int esc_seen = 0;
    for (int i = 0; i < 110; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (bw_if.state == 2'd1) chime_cyc++;
      if (bw_if.esc) esc_seen++;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_seq cyc %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (chime_cyc !== CT * TD) begin
      n_fail++;
      $display("FAIL chime_len: got %0d expected %0d", chime_cyc, CT * TD);
    end
    n_cmp++;
    if (esc_seen !== 110 - (CT * TD - 1) - ET * TD) begin
      n_fail++;
      $display("FAIL esc_len: got %0d expected %0d", esc_seen, 110 - (CT * TD - 1) - ET * TD);
    end
    $display("test_full_sequence done: %0d compared", n_cmp);
  endtask

  task automatic test_belt_cancel();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL belt_cancel cyc %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (got_vec() !== 5'b00000) begin
      n_fail++;
      $display("FAIL belt_cancel_off: got %b expected 00000", got_vec());
    end
    $display("test_belt_cancel done: %0d compared", n_cmp);
  endtask

  task automatic test_esc_restart();
    int chime_cyc = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 + CT * TD + ET * TD + 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (bw_if.state !== 2'd3) begin
      n_fail++;
      $display("FAIL esc_reached: got state %0d expected 3", bw_if.state);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL esc_drop cyc %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (bw_if.state == 2'd1) chime_cyc++;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL esc_restart cyc %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (chime_cyc !== CT * TD) begin
      n_fail++;
      $display("FAIL restart_chime_len: got %0d expected %0d", chime_cyc, CT * TD);
    end
    $display("test_esc_restart done: %0d compared", n_cmp);
  endtask

  task automatic test_reset_mid();
    int chime_cyc = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 + CT * TD + 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (got_vec() !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_mid: got %b expected 00000", got_vec());
    end
    for (int i = 0; i < 35; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (bw_if.state == 2'd1) chime_cyc++;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (chime_cyc !== CT * TD) begin
      n_fail++;
      $display("FAIL reset_mid_chime_len: got %0d expected %0d", chime_cyc, CT * TD);
    end
    $display("test_reset_mid done: %0d compared", n_cmp);
  endtask

  task automatic test_glitch();
    int chime_cyc = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      if (bw_if.state == 2'd1 && bw_if.lamp && bw_if.chime) chime_cyc++;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got %b expected %b", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (chime_cyc !== 1) begin
      n_fail++;
      $display("FAIL glitch_len: got %0d expected 1", chime_cyc);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (got_vec() !== 5'b00000) begin
        n_fail++;
        $display("FAIL key_off cyc %0d: got %b expected 00000", i, got_vec());
      end
    end
    $display("test_glitch done: %0d compared", n_cmp);
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int seg = 0; seg < 50; seg++) begin
      logic k, p, s, r;
      int len;
      k   = ($urandom % 5) != 0;
      p   = ($urandom % 5) != 0;
      s   = ($urandom % 4) == 0;
      len = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) begin
        r = ($urandom % 200) == 0;
        step(r, k, p, s);
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL random seg %0d cyc %0d: got %b expected %b", seg, i, got_vec(), exp_vec());
        end
      end
    end
    $display("test_random done: %0d compared", n_cmp);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_st = 0; m_wq = 1'b0; m_age = 0;
    rst = 1'b1; bw_if.K = 1'b0; bw_if.P = 1'b0; bw_if.S = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_sequence();
    test_belt_cancel();
    test_esc_restart();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
